// File: rtl/keypad_field_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_field_entry
// Purpose  : Decimal keypad entry engine for manual camera register setup.
//            Collects NUM_FIELDS decimal values of up to MAX_DIGITS digits
//            each (range limited to MAX_VAL), supports clear and backspace,
//            commits them to fields_out and strobes wr_start for the SCCB
//            master. Also drives a multiplexed hex display of the value
//            currently being typed.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            conf_en         - manual configuration enable
//            key_ready       - one-cycle strobe, key_code valid
//            key_code[3:0]   - 0-9 digit, A enter, B clear, C backspace
//            wr_busy         - SCCB master busy
//            scan            - keypad scan enable
//            fields_out      - committed fields, field i at [i*VAL_W +: VAL_W]
//            wr_start        - one-cycle strobe, fields_out complete
//            field_idx       - field currently being entered
//            key_err         - one-cycle strobe, key rejected
//            disp_num[3:0]   - hex nibble for the active display digit
//            disp_sel        - one-hot digit enable, bit 0 = LS nibble
// Revision : 1.0 - initial release
// ============================================================================
module keypad_field_entry #(
    parameter int VAL_W       = 8,
    parameter int MAX_VAL     = 255,
    parameter int MAX_DIGITS  = 3,
    parameter int NUM_FIELDS  = 2,
    parameter int DISP_DIGITS = 2,
    parameter int DISP_DIV    = 500000,
    localparam int FIDX_W     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        conf_en,
    input  logic                        key_ready,
    input  logic [3:0]                  key_code,
    input  logic                        wr_busy,
    output logic                        scan,
    output logic [NUM_FIELDS*VAL_W-1:0] fields_out,
    output logic                        wr_start,
    output logic [FIDX_W-1:0]           field_idx,
    output logic                        key_err,
    output logic [3:0]                  disp_num,
    output logic [DISP_DIGITS-1:0]      disp_sel
);

    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int CAND_W = VAL_W + 4;
    localparam int PAD_W  = DISP_DIGITS * 4;
    localparam int DIVC_W = ($clog2(DISP_DIV) > 18) ? $clog2(DISP_DIV) : 18;
    localparam int HIST_N = 2 ** CNT_W;

    localparam logic [3:0] c_key_enter = 4'hA;
    localparam logic [3:0] c_key_clear = 4'hB;
    localparam logic [3:0] c_key_back  = 4'hC;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_START = 2'd2
    } state_t;

    state_t              r_state;
    logic [VAL_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    // History of acc values before each accepted digit; r_cnt is the
    // stack pointer, so clearing r_cnt empties the stack.
    logic [VAL_W-1:0]    r_hist [HIST_N];
    logic [DIVC_W-1:0]   r_div_cnt;

    logic [CAND_W-1:0]   w_cand;
    logic                w_digit_ok;
    logic                w_last_field;
    logic [PAD_W-1:0]    w_acc_pad;
    logic [DISP_DIGITS-1:0] w_sel_rot;

    // Width of VAL_W+4 bits holds (2^VAL_W-1)*10+9 without overflow.
    assign w_cand       = {4'b0000, r_acc} * CAND_W'(10) + CAND_W'(key_code);
    assign w_digit_ok   = (r_cnt < CNT_W'(MAX_DIGITS)) && (w_cand <= CAND_W'(MAX_VAL));
    assign w_last_field = (field_idx == FIDX_W'(NUM_FIELDS - 1));

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            field_idx  <= '0;
            fields_out <= '0;
            scan       <= 1'b0;
            wr_start   <= 1'b0;
            key_err    <= 1'b0;
            for (int i = 0; i < HIST_N; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            wr_start <= 1'b0;
            key_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (conf_en) begin
                        r_state <= S_ENTRY;
                        scan    <= 1'b1;
                    end
                end

                S_ENTRY: begin
                    if (!conf_en) begin
                        // Leaving configuration abandons the partial entry
                        // but keeps the last committed fields.
                        r_state   <= S_IDLE;
                        scan      <= 1'b0;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        field_idx <= '0;
                    end else if (key_ready) begin
                        if (key_code <= 4'd9) begin
                            if (w_digit_ok) begin
                                r_hist[r_cnt] <= r_acc;
                                r_acc         <= w_cand[VAL_W-1:0];
                                r_cnt         <= r_cnt + CNT_W'(1);
                            end else begin
                                key_err <= 1'b1;
                            end
                        end else if (key_code == c_key_back) begin
                            if (r_cnt != '0) begin
                                r_acc <= r_hist[r_cnt - CNT_W'(1)];
                                r_cnt <= r_cnt - CNT_W'(1);
                            end else begin
                                key_err <= 1'b1;
                            end
                        end else if (key_code == c_key_clear) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                        end else if (key_code == c_key_enter) begin
                            if (r_cnt == '0) begin
                                key_err <= 1'b1;
                            end else if (!w_last_field) begin
                                fields_out[field_idx*VAL_W +: VAL_W] <= r_acc;
                                field_idx <= field_idx + FIDX_W'(1);
                                r_acc     <= '0;
                                r_cnt     <= '0;
                            end else if (!wr_busy) begin
                                fields_out[field_idx*VAL_W +: VAL_W] <= r_acc;
                                r_acc    <= '0;
                                r_cnt    <= '0;
                                wr_start <= 1'b1;
                                r_state  <= S_START;
                            end else begin
                                // Master busy: keep acc so Enter can be retried.
                                key_err <= 1'b1;
                            end
                        end
                    end
                end

                S_START: begin
                    field_idx <= '0;
                    if (conf_en) begin
                        r_state <= S_ENTRY;
                    end else begin
                        r_state <= S_IDLE;
                        scan    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    scan    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Multiplexed hex display
    // ------------------------------------------------------------------
    generate
        if (PAD_W > VAL_W) begin : g_pad
            assign w_acc_pad = {{(PAD_W - VAL_W){1'b0}}, r_acc};
        end else begin : g_trunc
            assign w_acc_pad = r_acc[PAD_W-1:0];
        end

        if (DISP_DIGITS > 1) begin : g_rot
            assign w_sel_rot = {disp_sel[DISP_DIGITS-2:0], disp_sel[DISP_DIGITS-1]};
        end else begin : g_norot
            assign w_sel_rot = disp_sel;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            disp_sel  <= DISP_DIGITS'(1);
        end else if (r_div_cnt == DIVC_W'(DISP_DIV - 1)) begin
            r_div_cnt <= '0;
            disp_sel  <= w_sel_rot;
        end else begin
            r_div_cnt <= r_div_cnt + DIVC_W'(1);
        end
    end

    always_comb begin
        disp_num = 4'h0;
        for (int i = 0; i < DISP_DIGITS; i++) begin
            if (disp_sel[i]) begin
                disp_num = w_acc_pad[i*4 +: 4];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_field_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_field_entry
// Purpose  : Directed self-checking bench for keypad_field_entry. One DUT
//            uses the default value/field shape with a fast display divider;
//            a second DUT uses 12-bit values, 3 fields and 3 display digits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_field_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic        conf_en, key_ready, wr_busy;
    logic [3:0]  key_code;
    logic        scan, wr_start, key_err;
    logic [15:0] fields_out;
    logic [0:0]  field_idx;
    logic [3:0]  disp_num;
    logic [1:0]  disp_sel;

    logic        conf_en2, key_ready2;
    logic [3:0]  key_code2;
    logic        scan2, wr_start2, key_err2;
    logic [35:0] fields_out2;
    logic [1:0]  field_idx2;
    logic [3:0]  disp_num2;
    logic [2:0]  disp_sel2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    keypad_field_entry #(
        .VAL_W(8), .MAX_VAL(255), .MAX_DIGITS(3), .NUM_FIELDS(2),
        .DISP_DIGITS(2), .DISP_DIV(4)
    ) dut (
        .clk(clk), .rst(rst), .conf_en(conf_en), .key_ready(key_ready),
        .key_code(key_code), .wr_busy(wr_busy), .scan(scan),
        .fields_out(fields_out), .wr_start(wr_start), .field_idx(field_idx),
        .key_err(key_err), .disp_num(disp_num), .disp_sel(disp_sel)
    );

    keypad_field_entry #(
        .VAL_W(12), .MAX_VAL(4095), .MAX_DIGITS(4), .NUM_FIELDS(3),
        .DISP_DIGITS(3), .DISP_DIV(4)
    ) dut2 (
        .clk(clk), .rst(rst), .conf_en(conf_en2), .key_ready(key_ready2),
        .key_code(key_code2), .wr_busy(1'b0), .scan(scan2),
        .fields_out(fields_out2), .wr_start(wr_start2), .field_idx(field_idx2),
        .key_err(key_err2), .disp_num(disp_num2), .disp_sel(disp_sel2)
    );

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_code  = c;
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    task automatic press2(input logic [3:0] c);
        @(negedge clk);
        key_code2  = c;
        key_ready2 = 1'b1;
        @(negedge clk);
        key_ready2 = 1'b0;
    endtask

    // Reassemble acc from the multiplexed display (8 cycles covers both slots).
    task automatic read_acc(output logic [7:0] v);
        v = 8'h00;
        repeat (8) begin
            @(negedge clk);
            if (disp_sel == 2'b01) v[3:0] = disp_num;
            else if (disp_sel == 2'b10) v[7:4] = disp_num;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (scan !== 1'b0) begin fails++; $display("FAIL reset_scan got %b want 0", scan); end
        tests++; if (wr_start !== 1'b0) begin fails++; $display("FAIL reset_wr_start got %b want 0", wr_start); end
        tests++; if (key_err !== 1'b0) begin fails++; $display("FAIL reset_key_err got %b want 0", key_err); end
        tests++; if (fields_out !== 16'h0000) begin fails++; $display("FAIL reset_fields got %h want 0000", fields_out); end
        tests++; if (field_idx !== 1'b0) begin fails++; $display("FAIL reset_field_idx got %b want 0", field_idx); end
        tests++; if (disp_sel !== 2'b01) begin fails++; $display("FAIL reset_disp_sel got %b want 01", disp_sel); end
        tests++; if (disp_num !== 4'h0) begin fails++; $display("FAIL reset_disp_num got %h want 0", disp_num); end
        tests++; if (disp_sel2 !== 3'b001) begin fails++; $display("FAIL reset_disp_sel2 got %b want 001", disp_sel2); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (scan !== 1'b0) begin fails++; $display("FAIL idle_scan got %b want 0", scan); end
    endtask

    task automatic test_two_fields;
        conf_en = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (scan !== 1'b1) begin fails++; $display("FAIL entry_scan got %b want 1", scan); end
        press(4'd2); press(4'd5); press(4'd5); press(4'hA);
        tests++; if (field_idx !== 1'b1) begin fails++; $display("FAIL tf_field_idx1 got %b want 1", field_idx); end
        tests++; if (fields_out[7:0] !== 8'hFF) begin fails++; $display("FAIL tf_field0 got %h want ff", fields_out[7:0]); end
        press(4'd1); press(4'd7);
        tests++; if (wr_start !== 1'b0) begin fails++; $display("FAIL tf_early_start got %b want 0", wr_start); end
        press(4'hA);
        tests++; if (wr_start !== 1'b1) begin fails++; $display("FAIL tf_wr_start got %b want 1", wr_start); end
        tests++; if (fields_out !== 16'h11FF) begin fails++; $display("FAIL tf_fields got %h want 11ff", fields_out); end
        @(negedge clk);
        tests++; if (wr_start !== 1'b0) begin fails++; $display("FAIL tf_start_len got %b want 0", wr_start); end
        tests++; if (field_idx !== 1'b0) begin fails++; $display("FAIL tf_field_idx0 got %b want 0", field_idx); end
    endtask

    task automatic test_range;
        logic [7:0] v;
        press(4'd2); press(4'd5);
        tests++; if (key_err !== 1'b0) begin fails++; $display("FAIL rg_ok_err got %b want 0", key_err); end
        press(4'd6);
        tests++; if (key_err !== 1'b1) begin fails++; $display("FAIL rg_max_err got %b want 1", key_err); end
        read_acc(v);
        tests++; if (v !== 8'h19) begin fails++; $display("FAIL rg_acc25 got %h want 19", v); end
        press(4'hB);
        tests++; if (key_err !== 1'b0) begin fails++; $display("FAIL rg_clear_err got %b want 0", key_err); end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        tests++; if (key_err !== 1'b1) begin fails++; $display("FAIL rg_digits_err got %b want 1", key_err); end
        press(4'hD);
        tests++; if (key_err !== 1'b0) begin fails++; $display("FAIL rg_unused_err got %b want 0", key_err); end
        read_acc(v);
        tests++; if (v !== 8'd123) begin fails++; $display("FAIL rg_acc123 got %h want 7b", v); end
        press(4'hB);
    endtask

    task automatic test_backspace;
        logic [7:0] v;
        press(4'd4); press(4'd7); press(4'hC);
        tests++; if (key_err !== 1'b0) begin fails++; $display("FAIL bs_err1 got %b want 0", key_err); end
        read_acc(v);
        tests++; if (v !== 8'd4) begin fails++; $display("FAIL bs_acc4 got %h want 04", v); end
        press(4'hC);
        read_acc(v);
        tests++; if (v !== 8'd0) begin fails++; $display("FAIL bs_acc0 got %h want 00", v); end
        press(4'hC);
        tests++; if (key_err !== 1'b1) begin fails++; $display("FAIL bs_empty_err got %b want 1", key_err); end
        press(4'hA);
        tests++; if (key_err !== 1'b1) begin fails++; $display("FAIL bs_enter_empty got %b want 1", key_err); end
    endtask

    task automatic test_busy;
        logic [7:0] v;
        wr_busy = 1'b1;
        press(4'd1); press(4'hA);
        press(4'd2); press(4'hA);
        tests++; if (key_err !== 1'b1) begin fails++; $display("FAIL busy_err got %b want 1", key_err); end
        tests++; if (wr_start !== 1'b0) begin fails++; $display("FAIL busy_start got %b want 0", wr_start); end
        read_acc(v);
        tests++; if (v !== 8'd2) begin fails++; $display("FAIL busy_acc got %h want 02", v); end
        wr_busy = 1'b0;
        press(4'hA);
        tests++; if (wr_start !== 1'b1) begin fails++; $display("FAIL busy_retry_start got %b want 1", wr_start); end
        tests++; if (fields_out !== 16'h0201) begin fails++; $display("FAIL busy_fields got %h want 0201", fields_out); end
        @(negedge clk);
    endtask

    task automatic test_conf_drop;
        logic [7:0] v;
        press(4'd5); press(4'hA);
        press(4'd9);
        conf_en = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (scan !== 1'b0) begin fails++; $display("FAIL cd_scan got %b want 0", scan); end
        tests++; if (field_idx !== 1'b0) begin fails++; $display("FAIL cd_field_idx got %b want 0", field_idx); end
        tests++; if (fields_out !== 16'h0205) begin fails++; $display("FAIL cd_fields got %h want 0205", fields_out); end
        press(4'd3);
        tests++; if (key_err !== 1'b0) begin fails++; $display("FAIL cd_idle_err got %b want 0", key_err); end
        read_acc(v);
        tests++; if (v !== 8'd0) begin fails++; $display("FAIL cd_acc got %h want 00", v); end
        conf_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_start;
        press(4'd3); press(4'hA); press(4'd4); press(4'hA);
        tests++; if (wr_start !== 1'b1) begin fails++; $display("FAIL rs_start got %b want 1", wr_start); end
        rst = 1'b1;
        #1;
        tests++; if (wr_start !== 1'b0) begin fails++; $display("FAIL rs_wr_start got %b want 0", wr_start); end
        tests++; if (fields_out !== 16'h0000) begin fails++; $display("FAIL rs_fields got %h want 0000", fields_out); end
        tests++; if (scan !== 1'b0) begin fails++; $display("FAIL rs_scan got %b want 0", scan); end
        tests++; if (field_idx !== 1'b0) begin fails++; $display("FAIL rs_field_idx got %b want 0", field_idx); end
        tests++; if (disp_sel !== 2'b01) begin fails++; $display("FAIL rs_disp_sel got %b want 01", disp_sel); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (scan !== 1'b1) begin fails++; $display("FAIL rs_reentry_scan got %b want 1", scan); end
    endtask

    task automatic test_display;
        logic [1:0] s;
        logic [3:0] n;
        bit         moved;
        press(4'd1); press(4'd6); press(4'd7);   // 167 = 8'hA7
        s = disp_sel;
        moved = 1'b0;
        for (int i = 0; i < 8 && !moved; i++) begin
            @(negedge clk);
            if (disp_sel !== s) moved = 1'b1;
        end
        tests++; if (!moved) begin fails++; $display("FAIL disp_rotate got no change want change within 8 cycles"); end
        s = disp_sel;
        for (int slot = 0; slot < 2; slot++) begin
            n = (s == 2'b01) ? 4'h7 : 4'hA;
            for (int k = 0; k < 4; k++) begin
                tests++; if (disp_sel !== s) begin fails++; $display("FAIL disp_sel got %b want %b", disp_sel, s); end
                tests++; if (disp_num !== n) begin fails++; $display("FAIL disp_num got %h want %h", disp_num, n); end
                @(negedge clk);
            end
            s = {s[0], s[1]};
        end
        press(4'hB);
    endtask

    task automatic test_wide;
        logic [2:0] mask;
        conf_en2 = 1'b1;
        repeat (2) @(negedge clk);
        press2(4'd4); press2(4'd0); press2(4'd9); press2(4'd5);
        tests++; if (key_err2 !== 1'b0) begin fails++; $display("FAIL wide_err got %b want 0", key_err2); end
        mask = 3'b000;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            mask = mask | disp_sel2;
            tests++; if (disp_num2 !== 4'hF) begin fails++; $display("FAIL wide_disp_num got %h want f sel %b", disp_num2, disp_sel2); end
        end
        tests++; if (mask !== 3'b111) begin fails++; $display("FAIL wide_sel_cover got %b want 111", mask); end
        press2(4'd1);
        tests++; if (key_err2 !== 1'b1) begin fails++; $display("FAIL wide_5th_digit got %b want 1", key_err2); end
    endtask

    initial begin
        rst = 1'b1; conf_en = 1'b0; key_ready = 1'b0; key_code = 4'h0; wr_busy = 1'b0;
        conf_en2 = 1'b0; key_ready2 = 1'b0; key_code2 = 4'h0;
        test_reset;
        test_two_fields;
        test_range;
        test_backspace;
        test_busy;
        test_conf_drop;
        test_reset_in_start;
        test_display;
        test_wide;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
